// File: rtl/seq_adder_pkg.sv
// Shared types and defaults for the time-multiplexed sequential adder.
// The optional overflow output is controlled by the SEQ_ADDER_OVF_EN macro.
package seq_adder_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/seq_adder64_ctrl_adder_slice.sv
// Combinational SLICE-bit adder shared by all slice positions of the sequencer.
// With SEQ_ADDER_OVF_EN defined it also exports the carry into its MSB.
module adder_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             ci_i,
  output logic [SLICE-1:0] s_o,
  output logic             co_o
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             cmsb_o
`endif
);

  // The low bits are summed one bit wider so the carry into the MSB falls out
  // directly; the MSB is then completed as a full adder.
  logic [SLICE-1:0] low_sum;
  logic             carry_msb;

  always_comb begin
    low_sum   = {1'b0, a_i[SLICE-2:0]} + {1'b0, b_i[SLICE-2:0]} + {{(SLICE-1){1'b0}}, ci_i};
    carry_msb = low_sum[SLICE-1];
    s_o       = {a_i[SLICE-1] ^ b_i[SLICE-1] ^ carry_msb, low_sum[SLICE-2:0]};
    co_o      = (a_i[SLICE-1] & b_i[SLICE-1]) |
                (a_i[SLICE-1] & carry_msb) |
                (b_i[SLICE-1] & carry_msb);
  end

`ifdef SEQ_ADDER_OVF_EN
  assign cmsb_o = carry_msb;
`endif

endmodule

// File: rtl/seq_adder64_ctrl.sv
// Sequential WIDTH-bit adder: one SLICE-bit adder reused over NSLICE cycles,
// valid/ready on both sides. SEQ_ADDER_OVF_EN adds the signed overflow output Ov.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; ready/valid are registered state decodes and never depend on the
// partner's signal in the same cycle, and a valid result is held until taken.
module seq_adder64_ctrl
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Ci,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
`ifdef SEQ_ADDER_OVF_EN
  output logic             Ov,
`endif
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] sum_d;
  logic             carry_d;

  assign slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

`ifdef SEQ_ADDER_OVF_EN
  logic ov_q;
  logic cmsb_d;

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .ci_i   (carry_q),
    .s_o    (sum_d),
    .co_o   (carry_d),
    .cmsb_o (cmsb_d)
  );
`else
  adder_slice #(.SLICE(SLICE)) u_slice (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .ci_i (carry_q),
    .s_o  (sum_d),
    .co_o (carry_d)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      co_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ov_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            carry_q    <= Ci;
            idx_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          s_q[int'(idx_q)*SLICE +: SLICE] <= sum_d;
          carry_q <= carry_d;
          if (idx_q == IDX_LAST) begin
            co_q        <= carry_d;
`ifdef SEQ_ADDER_OVF_EN
            ov_q        <= cmsb_d ^ carry_d;
`endif
            idx_q       <= '0;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Result is held here indefinitely; a new operand waits for IDLE.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign S           = s_q;
  assign Co          = co_q;
  assign dbg_state_o = state_q;
`ifdef SEQ_ADDER_OVF_EN
  assign Ov          = ov_q;
`endif

endmodule

// File: tb/tb_seq_adder64_ctrl.sv
// Self-checking bench for seq_adder64_ctrl against a plain-arithmetic model.
// Optional Ov checks follow SEQ_ADDER_OVF_EN.
module tb_seq_adder64_ctrl;

  localparam int W = 66;  // {ov, co, sum}

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Ci;
  logic [63:0] A;
  logic [63:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] S;
  logic        Co;
  logic        busy;
  logic [1:0]  dbg_state;
  logic        ov_w;

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  seq_adder64_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Ci          (Ci),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .S           (S),
    .Co          (Co),
`ifdef SEQ_ADDER_OVF_EN
    .Ov          (ov_w),
`endif
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

`ifndef SEQ_ADDER_OVF_EN
  assign ov_w = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: exact 65-bit sum, signed overflow from operand/result signs
  function automatic logic [W-1:0] ref_model(input logic [63:0] a, input logic [63:0] b, input logic ci);
    logic [64:0] full;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
`ifdef SEQ_ADDER_OVF_EN
    ov = (a[63] == b[63]) && (full[63] != a[63]);
`else
    ov = 1'b0;
`endif
    return {ov, full};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Ci = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, Co, ov_w} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags got=%b exp=%b", {in_ready, out_valid, busy, Co, ov_w}, 5'b10000);
    end
    checks++;
    if (S !== 64'd0) begin errors++; $display("FAIL reset_S got=%h exp=0", S); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  // one full transaction from IDLE, with latency and result checks, then handoff
  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input logic ci, input string name);
    logic [W-1:0] exp;
    int lat;
    exp = ref_model(a, b, ci);
    A = a; B = b; Ci = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL %s_latency got=%0d exp=4", name, lat); end
    checks++;
    if ({ov_w, Co, S} !== exp) begin
      errors++; $display("FAIL %s_result got=%h exp=%h", name, {ov_w, Co, S}, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL %s_handoff got=%b exp=010", name, {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_directed();
    run_txn(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, "small");
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "ripple");
    run_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "sign_ovf");
    run_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "neg_ovf");
  endtask

  task automatic test_stall();
    logic [W-1:0] exp1;
    logic [W-1:0] exp2;
    logic [63:0]  a2;
    logic [63:0]  b2;
    int lat;
    exp1 = ref_model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    exp2 = ref_model(a2, b2, 1'b0);
    A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; Ci = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    A = a2; B = b2; Ci = 1'b0;  // new operand stays offered the whole time
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101) begin
        errors++; $display("FAIL stall_flags cyc=%0d got=%b exp=101", i, {out_valid, in_ready, busy});
      end
      checks++;
      if ({ov_w, Co, S} !== exp1) begin
        errors++; $display("FAIL stall_result cyc=%0d got=%h exp=%h", i, {ov_w, Co, S}, exp1);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_release got=%b exp=01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      errors++; $display("FAIL stall_next_accept got=%b exp=10", {busy, in_ready});
    end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({ov_w, Co, S} !== exp2 || lat != 4) begin
      errors++; $display("FAIL stall_second got=%h lat=%0d exp=%h lat=4", {ov_w, Co, S}, lat, exp2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    A = 64'hFFFF_0000_FFFF_0000; B = 64'h0001_FFFF_0001_FFFF; Ci = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, Co, ov_w} !== 5'b10000) begin
      errors++; $display("FAIL midrst_flags got=%b exp=10000", {in_ready, out_valid, busy, Co, ov_w});
    end
    checks++;
    if (S !== 64'd0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL midrst_state S=%h st=%0d exp S=0 st=0", S, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(64'd5, 64'd7, 1'b0, "after_rst");
    checks++;
    if (S !== 64'd12) begin errors++; $display("FAIL after_rst_S got=%0d exp=12", S); end
  endtask

  task automatic test_back_to_back();
    int n_sent;
    int n_recv;
    int cyc;
    int last_acc;
    bit accepted;
    logic [W-1:0] exp;
    n_sent = 0; n_recv = 0; cyc = 0; last_acc = -1; accepted = 0;
    out_ready = 1'b1;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; Ci = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    while (n_recv < 1000 && cyc < 7000) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got=%h", {ov_w, Co, S});
        end else begin
          exp = exp_q.pop_front();
          if ({ov_w, Co, S} !== exp) begin
            errors++; $display("FAIL b2b_result n=%0d got=%h exp=%h", n_recv, {ov_w, Co, S}, exp);
          end
        end
        n_recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(A, B, Ci));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 6) begin
            errors++; $display("FAIL b2b_interval got=%0d exp=6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_sent++;
        accepted = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        accepted = 0;
        if (n_sent < 1000) begin
          case ($urandom_range(0, 3))
            0: begin A = '1; B = {63'd0, 1'($urandom_range(0, 1))}; end
            1: begin A = {1'b0, {63{1'b1}}}; B = {$urandom, $urandom}; end
            default: begin A = {$urandom, $urandom}; B = {$urandom, $urandom}; end
          endcase
          Ci = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (n_recv != 1000 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got=%0d left=%0d exp=1000 left=0", n_recv, exp_q.size());
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
